// File: rtl/ps2_key_rx_fifo.sv
// PS/2 keyboard receiver: line filtering, 11-bit framing with error and timeout detection,
// E0/F0 prefix tracking, scan-code set 2 to calculator symbol translation and an event FIFO.
module ps2_key_rx_fifo #(
  parameter int unsigned FILT_LEN     = 4,
  parameter int unsigned TIMEOUT_CYC  = 50000,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter bit          REPORT_BREAK = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DATA,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [15:0]                   evt_data,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_tmo,
  output logic                          overflow
);

  localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [FW-1:0] FiltMax = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TmoMax  = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck, StPush} state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser and glitch filter; bit 0 is the PS/2 clock, bit 1 the data line
  // ---------------------------------------------------------------------------
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          clk_prev_q;
  logic          fall;
  logic          bit_in;

  assign raw = {PS2_DATA, PS2_CLK};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FiltMax) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall   = clk_prev_q & ~filt_q[0];
  assign bit_in = filt_q[1];

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [10:0]   sr_q, sr_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          terr_q, terr_d;
  logic          wr_en;
  logic [7:0]    code;
  logic          frame_bad;
  logic          parity_ok;

  // Bits enter at the top, so after eleven shifts the start bit sits in sr_q[0]
  assign code      = sr_q[8:1];
  assign frame_bad = sr_q[0] | ~sr_q[10];
  assign parity_ok = ^sr_q[9:1];

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    tmo_d    = tmo_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    terr_d   = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          sr_d     = {bit_in, sr_q[10:1]};
          bitcnt_d = 4'd1;
          tmo_d    = '0;
          state_d  = StRecv;
        end
      end
      StRecv: begin
        if (fall) begin
          sr_d     = {bit_in, sr_q[10:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          tmo_d    = '0;
          if (bitcnt_q == 4'd10) begin
            state_d = StCheck;
          end
        end else if (tmo_q == TmoMax) begin
          terr_d  = 1'b1;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (frame_bad) begin
          ferr_d = 1'b1;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end else if (!parity_ok) begin
          perr_d = 1'b1;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end else if (code == 8'hE0) begin
          ext_d = 1'b1;
        end else if (code == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
          state_d = StPush;
        end
      end
      StPush: begin
        wr_en   = !(brk_q && !REPORT_BREAK);
        ext_d   = 1'b0;
        brk_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      bitcnt_q <= '0;
      tmo_q    <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      tmo_q    <= tmo_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      terr_q   <= terr_d;
    end
  end

  assign err_parity = perr_q;
  assign err_frame  = ferr_q;
  assign err_tmo    = terr_q;

  // ---------------------------------------------------------------------------
  // Scan code to calculator symbol
  // ---------------------------------------------------------------------------
  logic [4:0]  sym;
  logic        known;
  logic [15:0] evt_word;

  always_comb begin
    sym   = 5'd31;
    known = 1'b1;
    case (code)
      8'h70, 8'h45: sym = 5'd0;
      8'h69, 8'h16: sym = 5'd1;
      8'h72, 8'h1E: sym = 5'd2;
      8'h7A, 8'h26: sym = 5'd3;
      8'h6B, 8'h25: sym = 5'd4;
      8'h73, 8'h2E: sym = 5'd5;
      8'h74, 8'h36: sym = 5'd6;
      8'h6C, 8'h3D: sym = 5'd7;
      8'h75, 8'h3E: sym = 5'd8;
      8'h7D, 8'h46: sym = 5'd9;
      8'h79:        sym = 5'd10;
      8'h7B:        sym = 5'd11;
      8'h7C:        sym = 5'd12;
      8'h5A:        sym = 5'd14;
      8'h66:        sym = 5'd15;
      8'h76:        sym = 5'd16;
      // Keypad slash only exists as the extended code
      8'h4A: begin
        if (ext_q) begin
          sym = 5'd13;
        end else begin
          known = 1'b0;
        end
      end
      default:      known = 1'b0;
    endcase
  end

  assign evt_word = {brk_q, ext_q, known, sym, code};

  // ---------------------------------------------------------------------------
  // Show-ahead event FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          pop;
  logic          push;
  logic          ovf_q;

  assign full = (cnt_q == CntFull);
  assign pop  = evt_valid & evt_ready;
  // A pop in the same cycle frees the slot the write needs
  assign push = wr_en & (~full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= wr_en & full & ~pop;
      if (push) begin
        mem_q[wptr_q] <= evt_word;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign evt_valid = (cnt_q != '0);
  assign evt_data  = mem_q[rptr_q];
  assign evt_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_rx_fifo.sv
// Bench for ps2_key_rx_fifo: two instances (break reporting off/on) fed by the same PS/2 lines,
// checked against a queue-based key-event model.
module tb_ps2_key_rx_fifo;

  localparam int unsigned L     = 2;
  localparam int unsigned TC    = 40;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned HALF  = 6;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic [1:0]    evt_ready = 2'b00;
  logic [1:0]    evt_valid, err_parity, err_frame, err_tmo, overflow;
  logic [15:0]   evt_data [2];
  logic [CW-1:0] evt_count [2];

  always #5 clk = ~clk;

  ps2_key_rx_fifo #(.FILT_LEN(L), .TIMEOUT_CYC(TC), .FIFO_DEPTH(DEPTH), .REPORT_BREAK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .evt_valid(evt_valid[0]), .evt_ready(evt_ready[0]), .evt_data(evt_data[0]),
    .evt_count(evt_count[0]), .err_parity(err_parity[0]), .err_frame(err_frame[0]),
    .err_tmo(err_tmo[0]), .overflow(overflow[0])
  );

  ps2_key_rx_fifo #(.FILT_LEN(L), .TIMEOUT_CYC(TC), .FIFO_DEPTH(DEPTH), .REPORT_BREAK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .evt_valid(evt_valid[1]), .evt_ready(evt_ready[1]), .evt_data(evt_data[1]),
    .evt_count(evt_count[1]), .err_parity(err_parity[1]), .err_frame(err_frame[1]),
    .err_tmo(err_tmo[1]), .overflow(overflow[1])
  );

  // Reference tables: digits 0..9 in both key banks, then operator/control keys
  localparam logic [7:0] DIG_A [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                        8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  localparam logic [7:0] DIG_B [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                        8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] OP_C [6]   = '{8'h79, 8'h7B, 8'h7C, 8'h5A, 8'h66, 8'h76};
  localparam int         OP_S [6]   = '{10, 11, 12, 14, 15, 16};

  int n_pass = 0, n_total = 0;
  int perr_cnt [2] = '{0, 0};
  int ferr_cnt [2] = '{0, 0};
  int tmo_cnt  [2] = '{0, 0};
  int ovf_cnt  [2] = '{0, 0};
  int exp_perr = 0, exp_ferr = 0, exp_tmo = 0;
  int exp_ovf [2] = '{0, 0};
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic m_ext = 1'b0, m_brk = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (err_parity[k]) perr_cnt[k]++;
      if (err_frame[k])  ferr_cnt[k]++;
      if (err_tmo[k])    tmo_cnt[k]++;
      if (overflow[k])   ovf_cnt[k]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model_evt(input logic brk, input logic ext, input logic [7:0] c);
    int s = 31;
    for (int i = 0; i < 10; i++) if (c == DIG_A[i] || c == DIG_B[i]) s = i;
    for (int i = 0; i < 6; i++) if (c == OP_C[i]) s = OP_S[i];
    if (c == 8'h4A && ext) s = 13;
    return {brk, ext, (s != 31), 5'(s), c};
  endfunction

  function automatic void model_frame(input logic [7:0] c, input logic ferr, input logic perr);
    logic [15:0] ev;
    if (ferr) begin
      exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (perr) begin
      exp_perr++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (c == 8'hE0) begin
      m_ext = 1'b1;
    end else if (c == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      ev = model_evt(m_brk, m_ext, c);
      if (q1.size() < DEPTH) q1.push_back(ev); else exp_ovf[1]++;
      if (!m_brk) begin
        if (q0.size() < DEPTH) q0.push_back(ev); else exp_ovf[0]++;
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endfunction

  task automatic drive_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic bad_start, input logic bad_par,
                            input logic bad_stop, input logic meas);
    logic [10:0] f;
    f = {~bad_stop, (~^c) ^ bad_par, c, bad_start};
    model_frame(c, bad_start | bad_stop, bad_par);
    for (int i = 0; i < 10; i++) drive_bit(f[i]);
    ps2_data = f[10];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (meas) begin
      // Event leaves the FIFO head on the cycle it appears because evt_ready[0] is held high
      repeat (4 + L) @(posedge clk);
      #1 chk("lat_early", evt_valid[0], 1'b0);
      @(posedge clk);
      #1 chk("lat_valid", evt_valid[0], 1'b1);
      if (q0.size() > 0) begin
        chk("lat_data", evt_data[0], q0[0]);
        void'(q0.pop_front());
      end
      @(posedge clk);
      #1 chk("lat_popped", evt_count[0], 0);
      @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    logic [15:0] e;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk({tag, "_count"}, evt_count[k], (k == 0) ? q0.size() : q1.size());
      while ((k == 0) ? (q0.size() > 0) : (q1.size() > 0)) begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk({tag, "_data"}, evt_data[k], e);
        evt_ready[k] = 1'b1;
        @(negedge clk);
        evt_ready[k] = 1'b0;
      end
      chk({tag, "_empty"}, evt_valid[k], 1'b0);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_valid"}, evt_valid[k], 1'b0);
      chk({tag, "_count"}, evt_count[k], 0);
      chk({tag, "_data"}, evt_data[k], 16'h0000);
      chk({tag, "_errs"}, {err_parity[k], err_frame[k], err_tmo[k], overflow[k]}, 4'h0);
    end
  endtask

  task automatic chk_errs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_perr"}, perr_cnt[k], exp_perr);
      chk({tag, "_ferr"}, ferr_cnt[k], exp_ferr);
      chk({tag, "_tmo"}, tmo_cnt[k], exp_tmo);
      chk({tag, "_ovf"}, ovf_cnt[k], exp_ovf[k]);
    end
  endtask

  initial begin
    int cyc;
    int r;
    logic [7:0] c;
    logic [10:0] f;

    repeat (4) @(negedge clk);
    chk_idle("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single key, latency and immediate pop
    evt_ready[0] = 1'b1;
    send_frame(8'h69, 1'b0, 1'b0, 1'b0, 1'b1);
    evt_ready[0] = 1'b0;
    chk("t1_dut1_data", evt_data[1], 16'h2169);
    drain("t1");

    // Extended prefix
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_prefix_only", evt_count[0], 0);
    send_frame(8'h4A, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_slash", evt_data[0], 16'h6D4A);
    drain("t2");

    // Break prefix: dropped by dut0, reported by dut1
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h70, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_nobreak", evt_count[0], 0);
    chk("t3_break", evt_data[1], 16'hA070);
    drain("t3");

    // Parity and framing errors, then recovery
    send_frame(8'h70, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_par_pulse", perr_cnt[0], 1);
    chk("t4_par_noevt", evt_count[0], 0);
    send_frame(8'h7A, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h7A, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_frame_pulse", ferr_cnt[0], 2);
    chk("t4_frame_noperr", perr_cnt[0], 1);
    send_frame(8'h72, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("t4");
    chk_errs("t4");

    // Overflow with consumer stalled
    for (int i = 0; i < 9; i++) send_frame(DIG_A[i], 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_full0", evt_count[0], DEPTH);
    chk("t6_full1", evt_count[1], DEPTH);
    chk("t6_ovf_pulse", ovf_cnt[0], 1);
    drain("t6");
    chk_errs("t6");

    // Timeout after five bits
    c = 8'h5A;
    f = {1'b1, ~^c, c, 1'b0};
    for (int i = 0; i < 4; i++) drive_bit(f[i]);
    ps2_data = f[4];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    cyc = 0;
    while (err_tmo[0] !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc == HALF) ps2_clk = 1'b1;
    end
    chk("t5_tmo_latency", cyc, 3 + L + TC);
    chk("t5_tmo_dut1", err_tmo[1], 1'b1);
    @(posedge clk);
    #1 chk("t5_tmo_width", err_tmo[0], 1'b0);
    exp_tmo++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("t5");
    chk_errs("t5");

    // Reset in the middle of a frame with an event already queued
    send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
    f = {1'b1, ~^8'h76, 8'h76, 1'b0};
    for (int i = 0; i < 5; i++) drive_bit(f[i]);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("midrst");
    rst = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h4A, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("midrst");

    // Randomised key stream
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: c = 8'hE0;
        1: c = 8'hF0;
        2, 3: c = DIG_A[$urandom_range(0, 9)];
        4: c = DIG_B[$urandom_range(0, 9)];
        5: c = OP_C[$urandom_range(0, 5)];
        6: c = 8'h4A;
        default: c = 8'($urandom_range(0, 255));
      endcase
      send_frame(c, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0), 1'b0);
      if ($urandom_range(0, 2) == 0 || q1.size() >= DEPTH - 1) drain("rand");
    end
    drain("rand_end");
    chk_errs("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
